// File: rtl/div32.sv
// div32 -- sequential restoring divider, one quotient bit per clock.
//
// Shares the start/finish handshake of mul32. A start seen in IDLE latches
// the operands. Quotient, remainder and div_by_zero become valid together
// with finish, WIDTH cycles after the accepting edge. finish stays high while
// start is held. A new division needs start to drop and then rise again.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   dividend     numerator, sampled when start is accepted
//   divisor      denominator, sampled when start is accepted
//   is_signed    (DIV32_SIGNED_EN only) two's-complement operands
//   start        level request
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  registered flag, latched divisor was zero
//   finish       registered result-valid
//
// Optional feature: define DIV32_SIGNED_EN to add the is_signed port and
// truncating signed division (magnitudes through the same core, sign fix-up
// on the final step).
`timescale 1ns/1ps

module div32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV32_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic             start,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             finish
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] qw_q, qw_d;        // working quotient, starts as dividend
  logic [WIDTH-1:0] rw_q, rw_d;        // working remainder
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             zero_q, zero_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             finish_q, finish_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   r_shift, diff;
  logic             ge;
  logic [WIDTH-1:0] q_step, r_step;

`ifdef DIV32_SIGNED_EN
  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
`else
  assign a_neg = 1'b0;
  assign b_neg = 1'b0;
`endif

  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor  : divisor;

  // One restoring step, compared in WIDTH+1 bits so the shifted-out MSB
  // of the partial remainder is never lost.
  assign r_shift = {rw_q, qw_q[WIDTH-1]};
  assign diff    = r_shift - {1'b0, dvsr_q};
  assign ge      = ~diff[WIDTH];
  assign r_step  = ge ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
  assign q_step  = {qw_q[WIDTH-2:0], ge};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    qw_d        = qw_q;
    rw_d        = rw_q;
    dvsr_d      = dvsr_q;
    zero_d      = zero_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    finish_d    = finish_q;

    case (state_q)
      S_IDLE: begin
        finish_d = 1'b0;
        if (start) begin
          qw_d    = a_mag;
          rw_d    = '0;
          dvsr_d  = b_mag;
          zero_d  = (divisor == '0);
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        qw_d  = q_step;
        rw_d  = r_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          // Divide-by-zero quotient is all ones regardless of sign; the
          // remainder already equals the dividend after sign restoration.
          quotient_d  = zero_q ? '1 : (negq_q ? -q_step : q_step);
          remainder_d = negr_q ? -r_step : r_step;
          dbz_d       = zero_q;
          finish_d    = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) begin
          finish_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        finish_d = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      qw_q        <= '0;
      rw_q        <= '0;
      dvsr_q      <= '0;
      zero_q      <= 1'b0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      qw_q        <= qw_d;
      rw_q        <= rw_d;
      dvsr_q      <= dvsr_d;
      zero_q      <= zero_d;
      negq_q      <= negq_d;
      negr_q      <= negr_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      finish_q    <= finish_d;
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign finish      = finish_q;

endmodule

// File: tb/tb_div32.sv
// Bench for div32: directed vector table, hand-written handshake/reset
// sequences and randomized operands checked against an arithmetic model.
`timescale 1ns/1ps

module tb_div32;

  logic        clk;
  logic        rst;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        start;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        finish;
`ifdef DIV32_SIGNED_EN
  logic        is_signed;
`endif

  int vectors;
  int miscompares;
  int cyc;

  div32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef DIV32_SIGNED_EN
    .is_signed  (is_signed),
`endif
    .start      (start),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .finish     (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          s;
    int          hold;
    logic [31:0] q;
    logic [31:0] r;
    bit          z;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit s,
                                  output logic [31:0] q, output logic [31:0] r, output bit z);
    z = (b == 32'd0);
    if (z) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Waits (bounded) for finish; lat = cycles since the accepting edge, -1 on timeout.
  task automatic wait_finish(input int acc, output int lat);
    for (int i = 0; i < 45; i++) begin
      if (finish) break;
      @(posedge clk); #1;
    end
    lat = finish ? (cyc - acc) : -1;
  endtask

  // Full transaction: start held until finish plus `hold` extra cycles, then dropped.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input bit s, input int hold,
                        input logic [31:0] eq, input logic [31:0] er, input bit ez);
    int acc;
    int lat;
    @(negedge clk);
    dividend = a;
    divisor  = b;
`ifdef DIV32_SIGNED_EN
    is_signed = s;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    wait_finish(acc, lat);
    chk({tag, ".latency"}, lat, 32);
    chk({tag, ".quotient"}, quotient, eq);
    chk({tag, ".remainder"}, remainder, er);
    chk({tag, ".div_by_zero"}, {31'd0, div_by_zero}, {31'd0, ez});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".finish_held"}, {31'd0, finish}, 32'd1);
      chk({tag, ".q_held"}, quotient, eq);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, ".finish_drop"}, {31'd0, finish}, 32'd0);
    chk({tag, ".q_idle_hold"}, quotient, eq);
  endtask

  initial begin
    int acc;
    int lat;
    logic [31:0] ra, rb, eq, er;
    bit rs, ez;

    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
`ifdef DIV32_SIGNED_EN
    is_signed = 1'b0;
`endif

    #100;
    chk("reset.quotient", quotient, 32'd0);
    chk("reset.remainder", remainder, 32'd0);
    chk("reset.dbz", {31'd0, div_by_zero}, 32'd0);
    chk("reset.finish", {31'd0, finish}, 32'd0);
    rst = 1'b1;

    tbl.push_back('{32'd100,        32'd7,         1'b0, 3, 32'd14,        32'd2,    1'b0});
    tbl.push_back('{32'd20240321,   32'd1931,      1'b0, 0, 32'd10481,     32'd1510, 1'b0});
    tbl.push_back('{32'd6,          32'd0,         1'b0, 1, 32'hFFFF_FFFF, 32'd6,    1'b1});
    tbl.push_back('{32'd3,          32'd10,        1'b0, 0, 32'd0,         32'd3,    1'b0});
    tbl.push_back('{32'hFFFF_FFFF,  32'd1,         1'b0, 0, 32'hFFFF_FFFF, 32'd0,    1'b0});
    tbl.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 0, 32'd1,         32'd0,    1'b0});
    tbl.push_back('{32'd0,          32'd5,         1'b0, 0, 32'd0,         32'd0,    1'b0});
    tbl.push_back('{32'h8000_0000,  32'h8000_0001, 1'b0, 0, 32'd0,         32'h8000_0000, 1'b0});
`ifdef DIV32_SIGNED_EN
    tbl.push_back('{32'hFFFF_FFF9,  32'd2,         1'b1, 0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
    tbl.push_back('{32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 0, 32'h8000_0000, 32'd0,    1'b0});
    tbl.push_back('{32'hFFFF_FFF9,  32'd2,         1'b0, 0, 32'h7FFF_FFFC, 32'd1,    1'b0});
    tbl.push_back('{32'd7,          32'hFFFF_FFFE, 1'b1, 0, 32'hFFFF_FFFD, 32'd1,    1'b0});
    tbl.push_back('{32'hFFFF_FFF9,  32'd0,         1'b1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1});
`endif

    foreach (tbl[i])
      do_div($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].hold,
             tbl[i].q, tbl[i].r, tbl[i].z);

    // start pulsed for one cycle, operands changed and start re-pulsed mid-BUSY.
    @(negedge clk);
    dividend = 32'hFFFF_FFFF;
    divisor  = 32'd1;
`ifdef DIV32_SIGNED_EN
    is_signed = 1'b0;
`endif
    start = 1'b1;
    @(posedge clk); #1;
    acc = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    dividend = 32'd5;
    divisor  = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_finish(acc, lat);
    chk("pulse.latency", lat, 32);
    chk("pulse.quotient", quotient, 32'hFFFF_FFFF);
    chk("pulse.remainder", remainder, 32'd0);
    @(posedge clk); #1;
    chk("pulse.finish_one_cycle", {31'd0, finish}, 32'd0);
    repeat (2) @(posedge clk); #1;
    chk("pulse.no_retrigger", {31'd0, finish}, 32'd0);

    // Reset in the middle of BUSY.
    @(negedge clk);
    dividend = 32'd9;
    divisor  = 32'd9;
    start = 1'b1;
    @(posedge clk); #1;
    repeat (9) @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("midreset.quotient", quotient, 32'd0);
    chk("midreset.remainder", remainder, 32'd0);
    chk("midreset.finish", {31'd0, finish}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("midreset.no_result", {31'd0, finish}, 32'd0);
    do_div("restart", 32'd9, 32'd9, 1'b0, 0, 32'd1, 32'd0, 1'b0);

    // Randomized operands against the reference model.
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 255);
        2: rb = 32'd0;
        3: rb = ra >> $urandom_range(0, 31);
        default: rb = $urandom_range(1, 65535);
      endcase
`ifdef DIV32_SIGNED_EN
      rs = $urandom_range(0, 1) == 1;
`else
      rs = 1'b0;
`endif
      ref_div(ra, rb, rs, eq, er, ez);
      do_div($sformatf("rand%0d", n), ra, rb, rs, $urandom_range(0, 2), eq, er, ez);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
